// File: rtl/dac_output_sequencer.sv
// dac_output_sequencer: multi-channel DAC output stage with sample-rate strobe, per-channel mode, attenuation and offset-binary conversion
// Ports:
//   CLOCK_50, reset        clock and synchronous active-high reset
//   mode, shift            per-channel 2-bit mode (stream/DC/ramp/mute) and arithmetic right-shift, sampled on strobes
//   in_data, in_valid      per-channel signed stream samples with valid
//   in_ready               per-channel: sample consumed this cycle
//   dc_level, ramp_step    per-channel signed DC value and unsigned ramp increment
//   sample_en              one-cycle strobe every DIV cycles
//   dac_data               registered offset-binary DAC codes
//   underrun               per-channel sticky flag: stream strobe without a valid sample
module dac_output_sequencer #(
  parameter int N_CH = 2,
  parameter int DW = 14,
  parameter int DIV = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [2*N_CH-1:0]    mode,
  input  logic [2*N_CH-1:0]    shift,
  input  logic [N_CH*DW-1:0]   in_data,
  input  logic [N_CH-1:0]      in_valid,
  output logic [N_CH-1:0]      in_ready,
  input  logic [N_CH*DW-1:0]   dc_level,
  input  logic [N_CH*DW-1:0]   ramp_step,
  output logic                 sample_en,
  output logic [N_CH*DW-1:0]   dac_data,
  output logic [N_CH-1:0]      underrun
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] count;
  always_ff @(posedge CLOCK_50)
    count <= (reset || count == LAST) ? '0 : count + CW'(1);
  assign sample_en = count == LAST;
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [1:0] md, sh;
    logic signed [DW-1:0] din, dc, step, v, s, acc, last;
    logic [DW-1:0] dac;
    logic und;
    assign md = mode[2*k +: 2];
    assign sh = shift[2*k +: 2];
    assign din = $signed(in_data[DW*k +: DW]);
    assign dc = $signed(dc_level[DW*k +: DW]);
    assign step = $signed(ramp_step[DW*k +: DW]);
    // mute selects 0, so the shift below needs no mute special case
    always_comb begin
      v = md == 2'd0 ? (in_valid[k] ? din : last) : md == 2'd1 ? dc : md == 2'd2 ? acc : '0;
      s = v >>> sh;
    end
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        dac <= {1'b1, {(DW-1){1'b0}}};
        acc <= '0;
        last <= '0;
        und <= 1'b0;
      end else if (sample_en) begin
        dac <= {~s[DW-1], s[DW-2:0]};
        if (md == 2'd0 && in_valid[k]) last <= din;
        und <= und | (md == 2'd0 && !in_valid[k]);
        // accumulator wraps modulo 2^DW and restarts from 0 whenever the channel leaves ramp
        acc <= md == 2'd2 ? acc + step : '0;
      end
    end
    assign dac_data[DW*k +: DW] = dac;
    assign underrun[k] = und;
    assign in_ready[k] = sample_en & (md == 2'd0) & in_valid[k];
  end
endmodule

// File: tb/tb_dac_output_sequencer.sv
// tb_dac_output_sequencer: directed and randomized checks of dac_output_sequencer against a behavioural model
module tb_dac_output_sequencer;
  localparam int N_CH = 2, DW = 14, DIV = 4, H = 1 << (DW - 1), M = 1 << DW;
  logic CLOCK_50 = 0, reset = 1, sample_en;
  logic [2*N_CH-1:0] mode, shift;
  logic [N_CH*DW-1:0] in_data, dc_level, ramp_step, dac_data;
  logic [N_CH-1:0] in_valid, in_ready, underrun, rdy;
  int errors = 0, checks = 0;
  bit mvalid = 0;
  int t;
  int m_last[N_CH], m_acc[N_CH], m_code[N_CH];
  bit m_und[N_CH];

  dac_output_sequencer #(.N_CH(N_CH), .DW(DW), .DIV(DIV)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .mode(mode), .shift(shift),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dc_level(dc_level), .ramp_step(ramp_step), .sample_en(sample_en),
    .dac_data(dac_data), .underrun(underrun));

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] x);
    int u;
    u = int'(x);
    return u >= H ? u - M : u;
  endfunction

  // model: strobe in cycle t (counted from reset release) when t mod DIV == DIV-1
  always @(posedge CLOCK_50) begin
    if (reset) begin
      mvalid = 1;
      t = 0;
      for (int k = 0; k < N_CH; k++) begin
        m_last[k] = 0; m_acc[k] = 0; m_und[k] = 0; m_code[k] = H;
      end
    end else if (mvalid) begin
      if (t % DIV == DIV - 1)
        for (int k = 0; k < N_CH; k++) begin
          int md, sh, v, s;
          bit vl;
          md = int'(mode[2*k +: 2]);
          sh = int'(shift[2*k +: 2]);
          vl = in_valid[k];
          case (md)
            0: v = vl ? sx(in_data[DW*k +: DW]) : m_last[k];
            1: v = sx(dc_level[DW*k +: DW]);
            2: v = m_acc[k];
            default: v = 0;
          endcase
          if (md == 0 && vl) m_last[k] = v;
          if (md == 0 && !vl) m_und[k] = 1;
          s = md == 3 ? 0 : v >>> sh;
          m_code[k] = s + H;
          if (md == 2) begin
            int a;
            a = (m_acc[k] + int'(ramp_step[DW*k +: DW]) + M) % M;
            m_acc[k] = a >= H ? a - M : a;
          end else m_acc[k] = 0;
        end
      t++;
    end
  end

  always @(negedge CLOCK_50)
    if (mvalid) begin
      bit se;
      se = (t % DIV == DIV - 1);
      chk("sample_en", sample_en, se);
      for (int k = 0; k < N_CH; k++) begin
        chk($sformatf("in_ready[%0d]", k), in_ready[k], se && mode[2*k +: 2] == 2'd0 && in_valid[k]);
        chk($sformatf("dac_data[%0d]", k), dac_data[DW*k +: DW], m_code[k]);
        chk($sformatf("underrun[%0d]", k), underrun[k], m_und[k]);
      end
    end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic strobe_out();
    int i;
    i = 0;
    while (sample_en !== 1'b1 && i < 2 * DIV) begin
      step(1);
      i++;
    end
    if (sample_en !== 1'b1) chk("strobe_timeout", 0, 1);
    else step(1);
  endtask

  logic [11:0] se_pat = 12'b1000_1000_1000;

  initial begin
    int i;
    mode = '1; shift = '0; in_data = '0; in_valid = '0; dc_level = '0; ramp_step = '0;
    step(2);
    reset = 0;
    for (int c = 0; c < 12; c++) begin
      chk("reset_strobe_pattern", sample_en, se_pat[c]);
      step(1);
    end
    chk("reset_dac0", dac_data[13:0], 14'h2000);
    chk("reset_dac1", dac_data[27:14], 14'h2000);
    chk("reset_underrun", underrun, 2'b00);
    mode = {2'd3, 2'd0}; in_valid = 2'b01;
    in_data[13:0] = 14'h1FFF; strobe_out(); chk("stream_max", dac_data[13:0], 14'h3FFF);
    in_data[13:0] = 14'h2000; strobe_out(); chk("stream_min", dac_data[13:0], 14'h0000);
    in_data[13:0] = 14'h0000; strobe_out(); chk("stream_zero", dac_data[13:0], 14'h2000);
    in_data[13:0] = 14'd100; strobe_out(); chk("stream_100", dac_data[13:0], 14'h2064);
    in_valid = 2'b00; strobe_out();
    chk("underrun_repeat", dac_data[13:0], 14'h2064);
    chk("underrun_set", underrun[0], 1'b1);
    in_valid = 2'b01; in_data[13:0] = 14'd5; strobe_out();
    chk("after_underrun", dac_data[13:0], 14'h2005);
    chk("underrun_sticky", underrun[0], 1'b1);
    mode = {2'd2, 2'd3}; in_valid = 2'b00; ramp_step[27:14] = 14'h1000;
    strobe_out(); chk("ramp0", dac_data[27:14], 14'h2000);
    strobe_out(); chk("ramp1", dac_data[27:14], 14'h3000);
    strobe_out(); chk("ramp_wrap", dac_data[27:14], 14'h0000);
    strobe_out(); chk("ramp3", dac_data[27:14], 14'h1000);
    mode = {2'd1, 2'd3}; dc_level[27:14] = 14'h0000;
    strobe_out(); chk("ramp_to_dc", dac_data[27:14], 14'h2000);
    mode = {2'd2, 2'd3};
    strobe_out(); chk("ramp_restart", dac_data[27:14], 14'h2000);
    strobe_out(); chk("ramp_restart1", dac_data[27:14], 14'h3000);
    mode = {2'd3, 2'd1}; dc_level[13:0] = 14'h3FFB; shift = 4'b0001;
    strobe_out(); chk("dc_m5_sh1", dac_data[13:0], 14'h1FFD);
    shift = 4'b0011;
    strobe_out(); chk("dc_m5_sh3", dac_data[13:0], 14'h1FFF);
    shift = 4'b0000;
    strobe_out(); chk("dc_m5_sh0", dac_data[13:0], 14'h1FFB);
    step(1);
    mode = {2'd3, 2'd3};
    chk("mute_pending_a", dac_data[13:0], 14'h1FFB);
    step(1);
    chk("mute_pending_b", dac_data[13:0], 14'h1FFB);
    strobe_out(); chk("mute_applied", dac_data[13:0], 14'h2000);
    step(1);
    reset = 1; step(1); reset = 0;
    chk("midreset_underrun", underrun, 2'b00);
    chk("midreset_dac0", dac_data[13:0], 14'h2000);
    i = 0;
    while (sample_en !== 1'b1 && i < 20) begin
      step(1);
      i++;
    end
    chk("midreset_strobe_delay", i, 3);
    rdy = '0;
    for (int c = 0; c < 4000; c++) begin
      reset = $urandom_range(0, 499) == 0;
      for (int k = 0; k < N_CH; k++) begin
        if (!(in_valid[k] && !rdy[k])) begin
          in_valid[k] = $urandom_range(0, 9) < 8;
          in_data[DW*k +: DW] = DW'($urandom);
        end
        if ($urandom_range(0, 19) == 0) mode[2*k +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) shift[2*k +: 2] = 2'($urandom_range(0, 3));
        dc_level[DW*k +: DW] = DW'($urandom);
        if ($urandom_range(0, 29) == 0) ramp_step[DW*k +: DW] = DW'($urandom);
      end
      #2;
      rdy = in_ready;
      @(posedge CLOCK_50);
      #1;
    end
    reset = 0;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
